axil_req_arbiter: RTL

- Shares one AXI4-Lite master port between NUM_REQ requesters, typically CSR programming agents, in front of axilite_slave.
- Each requester issues a simple command: read or write, with address, data and strobe. It receives one response.
- Round-robin arbitration; exactly one AXI transaction is in flight at a time.
- Sequences the AW/W/B and AR/R channels with full valid/ready handshakes.

---
 rtl/axil_req_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/axil_req_arbiter.sv
// Round-robin arbiter that funnels simple read/write commands from NUM_REQ
// requesters onto a single AXI4-Lite master port, one transaction at a time.
module axil_req_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ-1:0]              req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_wstrb,
    output logic [NUM_REQ-1:0]              rsp_valid,
    input  logic [NUM_REQ-1:0]              rsp_ready,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic                            busy,
    output logic [ADDR_WIDTH-1:0]           m_AWADDR,
    output logic [2:0]                      m_AWPROT,
    output logic                            m_AWVALID,
    input  logic                            m_AWREADY,
    output logic [DATA_WIDTH-1:0]           m_WDATA,
    output logic [DATA_WIDTH/8-1:0]         m_WSTRB,
    output logic                            m_WVALID,
    input  logic                            m_WREADY,
    input  logic [1:0]                      m_BRESP,
    input  logic                            m_BVALID,
    output logic                            m_BREADY,
    output logic [ADDR_WIDTH-1:0]           m_ARADDR,
    output logic [2:0]                      m_ARPROT,
    output logic                            m_ARVALID,
    input  logic                            m_ARREADY,
    input  logic [DATA_WIDTH-1:0]           m_RDATA,
    input  logic [1:0]                      m_RRESP,
    input  logic                            m_RVALID,
    output logic                            m_RREADY
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int SW = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP
    } state_t;

    state_t                  state;
    logic [GW-1:0]           last_grant;
    logic [GW-1:0]           grant;
    logic [GW-1:0]           next_grant;
    logic [GW-1:0]           hi_grant;
    logic [GW-1:0]           lo_grant;
    logic                    hi_found;
    logic                    found;
    logic [NUM_REQ-1:0]      grant_mask;
    logic                    sel_write;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic [SW-1:0]           sel_wstrb;
    logic [ADDR_WIDTH-1:0]   cmd_addr;
    logic [DATA_WIDTH-1:0]   cmd_wdata;
    logic [SW-1:0]           cmd_wstrb;

    // Round robin: lowest requester above last_grant wins, else the lowest overall.
    always_comb begin
        // NOTE: every variable gets a default up front so no path can infer a latch.
        hi_found  = 1'b0;
        found     = 1'b0;
        hi_grant  = '0;
        lo_grant  = '0;
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wstrb = '0;
        req_ready = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                found    = 1'b1;
                lo_grant = GW'(i);
                if (GW'(i) > last_grant) begin
                    hi_found = 1'b1;
                    hi_grant = GW'(i);
                end
            end
        end
        next_grant = hi_found ? hi_grant : lo_grant;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_mask[i] = (GW'(i) == grant);
            if (GW'(i) == next_grant) begin
                sel_write    = req_write[i];
                sel_addr     = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata    = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_wstrb    = req_wstrb[i*SW +: SW];
                req_ready[i] = (state == IDLE) && found;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state      <= IDLE;
            last_grant <= GW'(NUM_REQ - 1);
            grant      <= '0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            cmd_wstrb  <= '0;
            m_AWVALID  <= 1'b0;
            m_WVALID   <= 1'b0;
            m_BREADY   <= 1'b0;
            m_ARVALID  <= 1'b0;
            m_RREADY   <= 1'b0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rsp_resp   <= '0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    grant     <= next_grant;
                    cmd_addr  <= sel_addr;
                    cmd_wdata <= sel_wdata;
                    cmd_wstrb <= sel_wstrb;
                    if (sel_write) begin
                        m_AWVALID <= 1'b1;
                        m_WVALID  <= 1'b1;
                        state     <= WR_ADDR_DATA;
                    end else begin
                        m_ARVALID <= 1'b1;
                        state     <= RD_ADDR;
                    end
                end
                WR_ADDR_DATA: begin
                    // AW and W complete independently; leave once neither is pending.
                    if (m_AWVALID && m_AWREADY) m_AWVALID <= 1'b0;
                    if (m_WVALID && m_WREADY) m_WVALID <= 1'b0;
                    if ((!m_AWVALID || m_AWREADY) && (!m_WVALID || m_WREADY)) begin
                        m_BREADY <= 1'b1;
                        state    <= WR_RESP;
                    end
                end
                WR_RESP: if (m_BVALID) begin
                    m_BREADY  <= 1'b0;
                    rsp_resp  <= m_BRESP;
                    rsp_rdata <= '0;
                    rsp_valid <= grant_mask;
                    state     <= RSP;
                end
                RD_ADDR: if (m_ARREADY) begin
                    m_ARVALID <= 1'b0;
                    m_RREADY  <= 1'b1;
                    state     <= RD_DATA;
                end
                RD_DATA: if (m_RVALID) begin
                    m_RREADY  <= 1'b0;
                    rsp_rdata <= m_RDATA;
                    rsp_resp  <= m_RRESP;
                    rsp_valid <= grant_mask;
                    state     <= RSP;
                end
                RSP: if (|(rsp_ready & grant_mask)) begin
                    rsp_valid  <= '0;
                    last_grant <= grant;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy     = (state != IDLE);
    assign m_AWADDR = cmd_addr;
    assign m_ARADDR = cmd_addr;
    assign m_WDATA  = cmd_wdata;
    assign m_WSTRB  = cmd_wstrb;
    assign m_AWPROT = 3'b000;
    assign m_ARPROT = 3'b000;
endmodule
